// File: rtl/litera_stream_cipher_pkg.sv
// Shared definitions for the rolling-key stream cipher: direction codes,
// controller states and the per-byte transform.
package litera_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // One byte through the additive cipher; wrap-around is implied by the 8-bit result.
  function automatic logic [7:0] lane_xform(input logic [7:0] data,
                                            input logic [7:0] key,
                                            input logic       mode);
    return (mode == MODE_DEC) ? (data - key) : (data + key);
  endfunction

endpackage

// File: rtl/litera_stream_cipher_if.sv
// Input and output stream of the cipher: valid/ready, data, last, and the
// per-message direction that travels with the input beat.
interface litera_stream_cipher_if #(
  parameter int LANES = 1
);

  logic               mode_i;
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic               out_last;

  // Source of input beats and sink of output beats.
  modport master (
    output mode_i, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The cipher itself.
  modport slave (
    input  mode_i, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/litera_stream_cipher_key_table.sv
// Rolling key storage: one write port, LANES read ports starting at base and
// wrapping modulo KEY_LEN (KEY_LEN is a power of two, so truncation wraps).
module litera_key_table #(
  parameter  int LANES   = 1,
  parameter  int KEY_LEN = 4,
  localparam int KW      = $clog2(KEY_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [KW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [KW-1:0]         base,
  output logic [LANES-1:0][7:0] rd_key
);

  logic [7:0] mem [KEY_LEN];

  // Key storage; clears on reset so the cipher starts as the identity.
  // NOTE: this memory is reset on purpose -- an all-zero key after reset is part of the behaviour, not a simulation convenience.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_LEN; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Lane j reads key[(base + j) mod KEY_LEN].
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      rd_key[j] = mem[KW'(32'(base) + 32'(j))];
    end
  end

endmodule

// File: rtl/litera_stream_cipher.sv
// Streaming rolling-key additive cipher. One registered output stage gives a
// one-cycle latency at full throughput; direction is fixed per message.
module litera_stream_cipher
  import litera_pkg::*;
#(
  parameter  int LANES   = 1,
  parameter  int KEY_LEN = 4,
  localparam int KW      = $clog2(KEY_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  litera_stream_cipher_if.slave  s,
  input  logic                   key_wr_en,
  input  logic [KW-1:0]          key_wr_addr,
  input  logic [7:0]             key_wr_data,
  output logic                   busy,
  output logic                   key_err
);

  state_t               state;
  state_t               state_next;
  logic [KW-1:0]        kidx;
  logic                 mode_q;
  logic                 eff_mode;
  logic                 in_fire;
  logic                 key_ok;
  logic [LANES-1:0][7:0] rd_key;
  logic [8*LANES-1:0]   xform;
  logic                 out_valid_q;
  logic [8*LANES-1:0]   out_data_q;
  logic                 out_last_q;

  assign s.in_ready  = !out_valid_q || s.out_ready;
  assign in_fire     = s.in_valid && s.in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign busy        = (state == BUSY);

  // The first beat of a message uses mode_i directly; later beats use the latched copy.
  assign eff_mode = (state == IDLE) ? s.mode_i : mode_q;

  // Key writes may not race a message: only in IDLE with no beat being accepted.
  assign key_ok = (state == IDLE) && !in_fire;

  litera_key_table #(
    .LANES   (LANES),
    .KEY_LEN (KEY_LEN)
  ) u_key_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (key_wr_en && key_ok),
    .wr_addr (key_wr_addr),
    .wr_data (key_wr_data),
    .base    (kidx),
    .rd_key  (rd_key)
  );

  // Per-lane transform of the incoming beat.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    xform = '0;
    for (int j = 0; j < LANES; j++) begin
      xform[8*j +: 8] = lane_xform(s.in_data[8*j +: 8], rd_key[j], eff_mode);
    end
  end

  // Message framing: BUSY between the first and the last beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire && !s.in_last) state_next = BUSY;
      BUSY:    if (in_fire &&  s.in_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, key index, latched mode and key-error pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      kidx    <= '0;
      mode_q  <= MODE_ENC;
      key_err <= 1'b0;
    end else begin
      state   <= state_next;
      key_err <= key_wr_en && !key_ok;
      if (in_fire) begin
        kidx <= s.in_last ? '0 : KW'(32'(kidx) + 32'(LANES));
        if (state == IDLE) mode_q <= s.mode_i;
      end
    end
  end

  // Registered output stage; holds its beat while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= xform;
      out_last_q  <= s.in_last;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_litera_stream_cipher.sv
// Bench for litera_stream_cipher: directed vectors plus randomized messages
// with random back-pressure, checked against a byte-level model where byte i
// of a message is combined with key[i mod KEY_LEN].
module tb_litera_stream_cipher;
  import litera_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Key buses: "a" feeds the single-lane DUT, "b" the chain pair and the 4-lane DUT.
  logic       key_en_a, key_en_b;
  logic [1:0] key_addr;
  logic [7:0] key_data;
  logic       busy_1, kerr_1, busy_e, kerr_e, busy_d, kerr_d, busy_4, kerr_4;

  logic [7:0] key_a [4];
  logic [7:0] key_b [4];

  litera_stream_cipher_if #(.LANES(1)) s1 ();
  litera_stream_cipher_if #(.LANES(1)) sa ();
  litera_stream_cipher_if #(.LANES(1)) sb ();
  litera_stream_cipher_if #(.LANES(4)) s4 ();

  litera_stream_cipher #(.LANES(1), .KEY_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .s(s1), .key_wr_en(key_en_a), .key_wr_addr(key_addr),
    .key_wr_data(key_data), .busy(busy_1), .key_err(kerr_1));

  litera_stream_cipher #(.LANES(1), .KEY_LEN(4)) u_enc (
    .clk(clk), .rst(rst), .s(sa), .key_wr_en(key_en_b), .key_wr_addr(key_addr),
    .key_wr_data(key_data), .busy(busy_e), .key_err(kerr_e));

  litera_stream_cipher #(.LANES(1), .KEY_LEN(4)) u_dec (
    .clk(clk), .rst(rst), .s(sb), .key_wr_en(key_en_b), .key_wr_addr(key_addr),
    .key_wr_data(key_data), .busy(busy_d), .key_err(kerr_d));

  litera_stream_cipher #(.LANES(4), .KEY_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .s(s4), .key_wr_en(key_en_b), .key_wr_addr(key_addr),
    .key_wr_data(key_data), .busy(busy_4), .key_err(kerr_4));

  // Encrypt instance feeds the decrypt instance directly.
  assign sb.in_valid = sa.out_valid;
  assign sb.in_data  = sa.out_data;
  assign sb.in_last  = sa.out_last;
  assign sa.out_ready = sb.in_ready;
  assign sb.mode_i   = MODE_DEC;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] b, input logic [7:0] k, input bit dec);
    return dec ? 8'(b - k) : 8'(b + k);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_key(input bit bus_b, input int addr, input logic [7:0] data);
    key_addr = 2'(addr);
    key_data = data;
    if (bus_b) key_en_b = 1'b1; else key_en_a = 1'b1;
    @(posedge clk); #1;
    key_en_a = 1'b0;
    key_en_b = 1'b0;
    @(negedge clk);
    if (bus_b) check("key_err_accepted_b", kerr_4, 1'b0);
    else       check("key_err_accepted_a", kerr_1, 1'b0);
    if (bus_b) key_b[addr] = data; else key_a[addr] = data;
    @(posedge clk); #1;
  endtask

  // Sends one message to the single-lane DUT with random sink back-pressure.
  task automatic run_msg1(input byte_q_t msg, input bit dec, input int rdy_pct);
    byte_q_t     exp;
    int          n, i, got, cyc;
    bit          fire, held;
    logic [7:0]  hd;
    logic        hl;
    n = msg.size();
    for (int k = 0; k < n; k++) exp.push_back(model_byte(msg[k], key_a[k % 4], dec));
    i = 0; got = 0; cyc = 0; held = 0; hd = '0; hl = 1'b0;
    s1.in_valid  = 1'b1;
    s1.in_data   = msg[0];
    s1.in_last   = (n == 1);
    s1.mode_i    = dec;
    s1.out_ready = ($urandom_range(99) < rdy_pct);
    while (got < n && cyc < 100 * n + 50) begin
      @(negedge clk);
      fire = s1.in_valid && s1.in_ready;
      if (s1.out_valid) begin
        if (held) begin
          check("stall_hold_data", s1.out_data, hd);
          check("stall_hold_last", s1.out_last, hl);
        end
        if (s1.out_ready) begin
          check("data", s1.out_data, exp[got]);
          check("last", s1.out_last, (got == n - 1));
          got++;
          held = 0;
        end else begin
          check("stall_in_ready", s1.in_ready, 1'b0);
          held = 1; hd = s1.out_data; hl = s1.out_last;
        end
      end else if (held) begin
        check("stall_hold_valid", s1.out_valid, 1'b1);
        held = 0;
      end
      @(posedge clk); #1;
      if (fire) i++;
      if (i < n) begin
        s1.in_valid = 1'b1;
        s1.in_data  = msg[i];
        s1.in_last  = (i == n - 1);
        s1.mode_i   = (i == 0) ? dec : 1'($urandom);
      end else begin
        s1.in_valid = 1'b0;
        s1.in_data  = 8'($urandom);
      end
      s1.out_ready = ($urandom_range(99) < rdy_pct);
      cyc++;
    end
    if (got < n) check("msg_timeout_beats", got, n);
    s1.in_valid  = 1'b0;
    s1.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("no_duplicate", s1.out_valid, 1'b0);
    check("idle_after_msg", busy_1, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    byte_q_t    msg;
    string      hello;
    int         total, len, i, got, cyc;
    bit         fire;
    logic [31:0] exp4;

    rst = 1'b1;
    key_en_a = 1'b0; key_en_b = 1'b0; key_addr = '0; key_data = '0;
    s1.in_valid = 0; s1.in_data = '0; s1.in_last = 0; s1.mode_i = 0; s1.out_ready = 1;
    sa.in_valid = 0; sa.in_data = '0; sa.in_last = 0; sa.mode_i = MODE_ENC; sb.out_ready = 1;
    s4.in_valid = 0; s4.in_data = '0; s4.in_last = 0; s4.mode_i = 0; s4.out_ready = 1;
    for (int k = 0; k < 4; k++) begin key_a[k] = 8'h00; key_b[k] = 8'h00; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", s1.out_valid, 1'b0);
    check("rst_out_data", s1.out_data, 8'h00);
    check("rst_out_last", s1.out_last, 1'b0);
    check("rst_busy", busy_1, 1'b0);
    check("rst_key_err", kerr_1, 1'b0);
    check("rst_in_ready", s1.in_ready, 1'b1);
    check("rst_out_valid4", s4.out_valid, 1'b0);
    @(posedge clk); #1;

    // Single beat with the zero key is the identity.
    msg = '{8'h50};
    run_msg1(msg, MODE_ENC, 100);

    // Load {03,10,FF,80} on both buses.
    write_key(0, 0, 8'h03); write_key(0, 1, 8'h10); write_key(0, 2, 8'hFF); write_key(0, 3, 8'h80);
    write_key(1, 0, 8'h03); write_key(1, 1, 8'h10); write_key(1, 2, 8'hFF); write_key(1, 3, 8'h80);

    // Five-beat encrypt with key index wrap, then decrypt back.
    msg = '{8'h50, 8'h50, 8'h50, 8'h50, 8'h50};
    run_msg1(msg, MODE_ENC, 100);
    msg = '{8'h53, 8'h60, 8'h4F, 8'hD0, 8'h53};
    run_msg1(msg, MODE_DEC, 100);

    // Encrypt -> decrypt loopback recovers the plaintext.
    hello = "HELLO";
    i = 0; got = 0; cyc = 0;
    sa.in_valid = 1'b1; sa.in_data = hello[0]; sa.in_last = 1'b0;
    while (got < 5 && cyc < 200) begin
      @(negedge clk);
      fire = sa.in_valid && sa.in_ready;
      if (sb.out_valid) begin
        check("chain_data", sb.out_data, hello[got]);
        check("chain_last", sb.out_last, (got == 4));
        got++;
      end
      @(posedge clk); #1;
      if (fire) i++;
      if (i < 5) begin
        sa.in_valid = 1'b1; sa.in_data = hello[i]; sa.in_last = (i == 4);
      end else begin
        sa.in_valid = 1'b0;
      end
      cyc++;
    end
    if (got < 5) check("chain_timeout_beats", got, 5);

    // Key write during BUSY is rejected.
    s1.out_ready = 1'b1;
    s1.in_valid = 1'b1; s1.in_data = 8'h11; s1.in_last = 1'b0; s1.mode_i = MODE_ENC;
    @(posedge clk); #1;
    s1.in_valid = 1'b0;
    key_en_a = 1'b1; key_addr = 2'd1; key_data = 8'hAA;
    @(negedge clk);
    check("busy_mid_msg", busy_1, 1'b1);
    check("busy_beat0", s1.out_data, model_byte(8'h11, key_a[0], 0));
    @(posedge clk); #1;
    key_en_a = 1'b0;
    @(negedge clk);
    check("key_err_busy", kerr_1, 1'b1);
    @(posedge clk); #1;
    s1.in_valid = 1'b1; s1.in_data = 8'h22; s1.in_last = 1'b1; s1.mode_i = MODE_DEC;
    @(negedge clk);
    check("key_err_pulse_end", kerr_1, 1'b0);
    @(posedge clk); #1;
    s1.in_valid = 1'b0;
    @(negedge clk);
    check("busy_beat1", s1.out_data, model_byte(8'h22, key_a[1], 0));
    check("busy_beat1_last", s1.out_last, 1'b1);
    check("busy_cleared", busy_1, 1'b0);
    @(posedge clk); #1;

    // Key write in the same cycle as an IDLE in_fire is rejected.
    s1.in_valid = 1'b1; s1.in_data = 8'h30; s1.in_last = 1'b1; s1.mode_i = MODE_ENC;
    key_en_a = 1'b1; key_addr = 2'd0; key_data = 8'h77;
    @(posedge clk); #1;
    s1.in_valid = 1'b0; key_en_a = 1'b0;
    @(negedge clk);
    check("key_err_fire", kerr_1, 1'b1);
    check("fire_beat", s1.out_data, model_byte(8'h30, key_a[0], 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("key_err_fire_end", kerr_1, 1'b0);
    @(posedge clk); #1;
    msg = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_msg1(msg, MODE_ENC, 100);

    // Random key, then 64 random beats in random-length messages under 50% back-pressure.
    for (int k = 0; k < 4; k++) write_key(0, k, 8'($urandom));
    total = 0;
    while (total < 64) begin
      len = $urandom_range(1, 12);
      if (total + len > 64) len = 64 - total;
      msg = {};
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
      run_msg1(msg, 1'($urandom), 50);
      total += len;
    end

    // Four lanes per beat.
    s4.in_valid = 1'b1; s4.in_data = 32'h5050_5050; s4.in_last = 1'b1; s4.mode_i = MODE_ENC;
    @(posedge clk); #1;
    s4.in_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) exp4[8*j +: 8] = model_byte(8'h50, key_b[j], 0);
    check("lanes4_data", s4.out_data, exp4);
    check("lanes4_last", s4.out_last, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of a two-beat message.
    s4.in_valid = 1'b1; s4.in_data = 32'h0102_0304; s4.in_last = 1'b0;
    @(posedge clk); #1;
    s4.in_valid = 1'b0;
    @(negedge clk);
    check("lanes4_busy", busy_4, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin key_a[k] = 8'h00; key_b[k] = 8'h00; end
    @(negedge clk);
    check("midrst_out_valid", s4.out_valid, 1'b0);
    check("midrst_busy", busy_4, 1'b0);
    @(posedge clk); #1;
    s4.in_valid = 1'b1; s4.in_data = 32'h5050_5050; s4.in_last = 1'b1;
    @(posedge clk); #1;
    s4.in_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) exp4[8*j +: 8] = model_byte(8'h50, key_b[j], 0);
    check("postrst_data", s4.out_data, exp4);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
